lsu_dmem: RTL and testbench

Parametrised load/store unit with integrated byte-addressed data memory for the RV32I pipeline's MEM stage. It supports every RV32I access size with little-endian byte lanes and load sign/zero extension. Read latency is configurable and handled through a valid/ready handshake, so the pipeline stalls instead of assuming single-cycle memory. Misaligned and out-of-range accesses are reported as faults.

---
 rtl/lsu_dmem.sv | 192 +++++++++++++++++++
 tb/tb_lsu_dmem.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dmem.sv
// lsu_dmem: RV32I load/store unit with byte-addressed data memory.
// Define LSU_SUBWORD_EN for B/H/BU/HU accesses; default build is word-only.
module lsu_dmem #(
    parameter int    DEPTH_BYTES = 64,
    parameter int    LATENCY     = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    output logic [4:0]  resp_rd,
    output logic [31:0] resp_data,
    output logic        fault
);
    localparam int AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam logic [1:0] CNT_INIT = 2'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  cnt;
    logic [1:0]  cnt_nxt;

    logic [7:0]  mem [DEPTH_BYTES];

    logic [AW-1:0] addr_q;
    logic [4:0]    rd_q;
`ifdef LSU_SUBWORD_EN
    logic [2:0]    f3_q;
    logic [2:0]    rd_f3;
`endif

    logic          accept;
    logic          legal;
    logic          f3_ok;
    logic          align_ok;
    logic [2:0]    size;
    logic [32:0]   end_addr;
    logic          ld_acc;
    logic          st_acc;
    logic          bad;

    logic [AW-1:0] rd_idx;
    logic [4:0]    rd_tag;
    logic [7:0]    rbyte [4];
    logic [31:0]   ext;

    // Request decode: size, alignment, funct3 legality and range.
    always_comb begin
        size     = 3'd4;
        align_ok = 1'b1;
        f3_ok    = 1'b0;
`ifdef LSU_SUBWORD_EN
        unique case (1'b1)
            req_funct3[1:0] == 2'b00: size = 3'd1;
            req_funct3[1:0] == 2'b01: begin
                size     = 3'd2;
                align_ok = !req_addr[0];
            end
            default: begin
                size     = 3'd4;
                align_ok = req_addr[1:0] == 2'b00;
            end
        endcase
        if (req_write)
            f3_ok = req_funct3 inside {3'b000, 3'b001, 3'b010};
        else
            f3_ok = req_funct3 inside {3'b000, 3'b001, 3'b010,
                                       3'b100, 3'b101};
`else
        align_ok = req_addr[1:0] == 2'b00;
        f3_ok    = req_funct3 == 3'b010;
`endif
        end_addr = {1'b0, req_addr} + 33'(size);
        legal    = f3_ok && align_ok && (end_addr <= 33'(DEPTH_BYTES));
    end

    assign accept = req_valid && req_ready;
    assign ld_acc = accept && legal && !req_write;
    assign st_acc = accept && legal && req_write;
    assign bad    = accept && !legal;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE, RESP: begin
                state_nxt = IDLE;
                if (ld_acc) begin
                    cnt_nxt   = CNT_INIT;
                    state_nxt = (CNT_INIT == 2'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 2'd1;
                if (cnt == 2'd1) state_nxt = RESP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = state != WAIT;
        resp_valid = state == RESP;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q <= '0;
            rd_q   <= '0;
`ifdef LSU_SUBWORD_EN
            f3_q   <= '0;
`endif
        end else if (ld_acc) begin
            addr_q <= req_addr[AW-1:0];
            rd_q   <= req_rd;
`ifdef LSU_SUBWORD_EN
            f3_q   <= req_funct3;
`endif
        end
    end

    // Zero-latency loads read straight from the request, others from the latch.
    always_comb begin
        rd_idx = (state == WAIT) ? addr_q : req_addr[AW-1:0];
        rd_tag = (state == WAIT) ? rd_q : req_rd;
`ifdef LSU_SUBWORD_EN
        rd_f3  = (state == WAIT) ? f3_q : req_funct3;
`endif
        for (int k = 0; k < 4; k++)
            rbyte[k] = mem[rd_idx + AW'(k)];
    end

    always_comb begin
        ext = {rbyte[3], rbyte[2], rbyte[1], rbyte[0]};
`ifdef LSU_SUBWORD_EN
        unique case (1'b1)
            rd_f3 == 3'b000: ext = {{24{rbyte[0][7]}}, rbyte[0]};
            rd_f3 == 3'b100: ext = {24'b0, rbyte[0]};
            rd_f3 == 3'b001: ext = {{16{rbyte[1][7]}}, rbyte[1], rbyte[0]};
            rd_f3 == 3'b101: ext = {16'b0, rbyte[1], rbyte[0]};
            default:         ext = {rbyte[3], rbyte[2], rbyte[1], rbyte[0]};
        endcase
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            resp_data <= '0;
            resp_rd   <= '0;
            fault     <= 1'b0;
        end else begin
            fault <= bad;
            if (state_nxt == RESP) begin
                resp_data <= ext;
                resp_rd   <= rd_tag;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && st_acc) begin
            for (int k = 0; k < 4; k++) begin
`ifdef LSU_SUBWORD_EN
                if (3'(k) < size)
                    mem[req_addr[AW-1:0] + AW'(k)] <= req_wdata[8*k +: 8];
`else
                mem[req_addr[AW-1:0] + AW'(k)] <= req_wdata[8*k +: 8];
`endif
            end
        end
    end

endmodule

// File: tb/tb_lsu_dmem.sv
// tb_lsu_dmem: scoreboard bench for lsu_dmem at latencies 1, 3 and 4.
// Stimulus pushes expected responses/faults; a negedge monitor pops them.
module tb_lsu_dmem;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset      [3];
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        req_write  [3];
    logic [2:0]  req_funct3 [3];
    logic [31:0] req_addr   [3];
    logic [31:0] req_wdata  [3];
    logic [4:0]  req_rd     [3];
    logic        resp_valid [3];
    logic [4:0]  resp_rd    [3];
    logic [31:0] resp_data  [3];
    logic        fault      [3];

    int edge_n = 0;
    always @(posedge clock) edge_n <= edge_n + 1;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        int          cyc;
        logic        flt;
        logic [4:0]  rd;
        logic [31:0] data;
    } ev_t;

    ev_t sbq [3][$];

    lsu_dmem #(.DEPTH_BYTES(64), .LATENCY(1)) u_l1 (
        .clock(clock), .reset(reset[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_funct3(req_funct3[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_rd(req_rd[0]), .resp_valid(resp_valid[0]),
        .resp_rd(resp_rd[0]), .resp_data(resp_data[0]),
        .fault(fault[0])
    );

    lsu_dmem #(.DEPTH_BYTES(62), .LATENCY(3)) u_l3 (
        .clock(clock), .reset(reset[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_funct3(req_funct3[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_rd(req_rd[1]), .resp_valid(resp_valid[1]),
        .resp_rd(resp_rd[1]), .resp_data(resp_data[1]),
        .fault(fault[1])
    );

    lsu_dmem #(.DEPTH_BYTES(64), .LATENCY(4)) u_l4 (
        .clock(clock), .reset(reset[2]),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_write(req_write[2]), .req_funct3(req_funct3[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .req_rd(req_rd[2]), .resp_valid(resp_valid[2]),
        .resp_rd(resp_rd[2]), .resp_data(resp_data[2]),
        .fault(fault[2])
    );

    function automatic int lat(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h want 0x%08h (edge %0d)",
                     name, act, exp, edge_n);
        end
    endtask

    // Monitor: every resp_valid/fault pulse must match the queue head.
    always @(negedge clock) begin
        ev_t e;
        for (int i = 0; i < 3; i++) begin
            while (sbq[i].size() > 0 && sbq[i][0].cyc < edge_n) begin
                e = sbq[i].pop_front();
                checks++;
                failures++;
                $display("FAIL missed_u%0d: event due at edge %0d not seen",
                         i, e.cyc);
            end
            if (resp_valid[i] === 1'b1) begin
                if (sbq[i].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp_u%0d: data 0x%08h at edge %0d",
                             i, resp_data[i], edge_n);
                end else begin
                    e = sbq[i].pop_front();
                    check($sformatf("resp_cycle_u%0d", i), edge_n, e.cyc);
                    check($sformatf("resp_kind_u%0d", i), 32'(e.flt), 32'd0);
                    check($sformatf("resp_rd_u%0d", i), 32'(resp_rd[i]),
                          32'(e.rd));
                    check($sformatf("resp_data_u%0d", i), resp_data[i], e.data);
                end
            end
            if (fault[i] === 1'b1) begin
                if (sbq[i].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_fault_u%0d: at edge %0d",
                             i, edge_n);
                end else begin
                    e = sbq[i].pop_front();
                    check($sformatf("fault_cycle_u%0d", i), edge_n, e.cyc);
                    check($sformatf("fault_kind_u%0d", i), 32'(e.flt), 32'd1);
                end
            end
        end
    end

    task automatic issue(input int i, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] rd, input bit flt,
                         input logic [31:0] ed, input bit track,
                         output int t);
        int  n;
        ev_t e;
        req_valid[i]  = 1'b1;
        req_write[i]  = wr;
        req_funct3[i] = f3;
        req_addr[i]   = a;
        req_wdata[i]  = wd;
        req_rd[i]     = rd;
        n = 0;
        while (req_ready[i] !== 1'b1 && n < 10) begin
            @(negedge clock);
            n++;
        end
        t = edge_n + 1;
        if (req_ready[i] !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout_u%0d: req_ready low %0d cycles", i, n);
            t = -1;
        end else if (track && (flt || !wr)) begin
            e.cyc  = flt ? t : t + lat(i) - 1;
            e.flt  = flt;
            e.rd   = rd;
            e.data = ed;
            sbq[i].push_back(e);
        end
        @(negedge clock);
        req_valid[i] = 1'b0;
    endtask

    task automatic st(input int i, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d);
        int t;
        issue(i, 1'b1, f3, a, d, 5'd0, 1'b0, 32'd0, 1'b1, t);
    endtask

    task automatic ld(input int i, input logic [2:0] f3, input logic [31:0] a,
                      input logic [4:0] rd, input logic [31:0] exp);
        int t;
        issue(i, 1'b0, f3, a, 32'd0, rd, 1'b0, exp, 1'b1, t);
    endtask

    task automatic bad(input int i, input bit wr, input logic [2:0] f3,
                       input logic [31:0] a);
        int t;
        issue(i, wr, f3, a, 32'h5555_5555, 5'd1, 1'b1, 32'd0, 1'b1, t);
    endtask

    task automatic chk_reset(input int i);
        check($sformatf("rst_ready_u%0d", i), 32'(req_ready[i]), 32'd1);
        check($sformatf("rst_valid_u%0d", i), 32'(resp_valid[i]), 32'd0);
        check($sformatf("rst_rd_u%0d", i), 32'(resp_rd[i]), 32'd0);
        check($sformatf("rst_data_u%0d", i), resp_data[i], 32'd0);
        check($sformatf("rst_fault_u%0d", i), 32'(fault[i]), 32'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) > 0 && n < 40) begin
            @(negedge clock);
            n++;
        end
        repeat (2) @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t1;
        int t2;
        ev_t e;
        for (int i = 0; i < 3; i++) begin
            reset[i]      = 1'b1;
            req_valid[i]  = 1'b0;
            req_write[i]  = 1'b0;
            req_funct3[i] = 3'b000;
            req_addr[i]   = 32'd0;
            req_wdata[i]  = 32'd0;
            req_rd[i]     = 5'd0;
        end
        repeat (3) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            chk_reset(i);
            reset[i] = 1'b0;
        end
        @(negedge clock);

        // Latency 1: word round trip, faults, boundaries.
        st(0, 3'b010, 32'h8, 32'hDEAD_BEEF);
        ld(0, 3'b010, 32'h8, 5'd5, 32'hDEAD_BEEF);
        bad(0, 1'b1, 3'b010, 32'h6);
        bad(0, 1'b0, 3'b010, 32'h6);
        bad(0, 1'b0, 3'b001, 32'h3);
        bad(0, 1'b0, 3'b011, 32'h8);
        bad(0, 1'b1, 3'b011, 32'h8);
        bad(0, 1'b0, 3'b010, 32'h40);
        bad(0, 1'b0, 3'b010, 32'hFFFF_FFFC);
        ld(0, 3'b010, 32'h8, 5'd6, 32'hDEAD_BEEF);
        st(0, 3'b010, 32'h3C, 32'h0A0B_0C0D);
        ld(0, 3'b010, 32'h3C, 5'd1, 32'h0A0B_0C0D);
        issue(0, 1'b0, 3'b010, 32'h8, 32'd0, 5'd10, 1'b0, 32'hDEAD_BEEF, 1'b1, t1);
        check("ready_l1", 32'(req_ready[0]), 32'd1);
        issue(0, 1'b0, 3'b010, 32'h3C, 32'd0, 5'd11, 1'b0, 32'h0A0B_0C0D, 1'b1, t2);
        check("b2b_gap_l1", t2 - t1, 32'd1);
`ifdef LSU_SUBWORD_EN
        ld(0, 3'b100, 32'h8, 5'd2, 32'h0000_00EF);
        ld(0, 3'b100, 32'h9, 5'd2, 32'h0000_00BE);
        ld(0, 3'b100, 32'hA, 5'd2, 32'h0000_00AD);
        ld(0, 3'b100, 32'hB, 5'd2, 32'h0000_00DE);
        st(0, 3'b000, 32'h9, 32'h0000_0080);
        ld(0, 3'b000, 32'h9, 5'd3, 32'hFFFF_FF80);
        ld(0, 3'b100, 32'h9, 5'd4, 32'h0000_0080);
        ld(0, 3'b001, 32'h8, 5'd5, 32'hFFFF_80EF);
        ld(0, 3'b101, 32'hA, 5'd6, 32'h0000_DEAD);
        st(0, 3'b001, 32'h2, 32'hFFFF_1234);
        ld(0, 3'b001, 32'h2, 5'd7, 32'h0000_1234);
        ld(0, 3'b000, 32'h3, 5'd8, 32'h0000_0012);
        bad(0, 1'b1, 3'b100, 32'h8);
        bad(0, 1'b0, 3'b110, 32'h8);
        bad(0, 1'b0, 3'b001, 32'h9);
        ld(0, 3'b010, 32'h8, 5'd9, 32'hDEAD_80EF);
`else
        st(0, 3'b010, 32'h0, 32'hCAFE_F00D);
        bad(0, 1'b0, 3'b000, 32'h0);
        bad(0, 1'b1, 3'b000, 32'h0);
        bad(0, 1'b0, 3'b100, 32'h0);
        ld(0, 3'b010, 32'h0, 5'd4, 32'hCAFE_F00D);
`endif
        drain();

        // Latency 3, 62-byte memory: stall window and range edge.
        st(1, 3'b010, 32'h38, 32'h0102_0304);
        bad(1, 1'b1, 3'b010, 32'h3C);
        bad(1, 1'b0, 3'b010, 32'h3C);
        issue(1, 1'b0, 3'b010, 32'h38, 32'd0, 5'd2, 1'b0, 32'h0102_0304, 1'b1, t1);
        check("ready_wait1_l3", 32'(req_ready[1]), 32'd0);
        @(negedge clock);
        check("ready_wait2_l3", 32'(req_ready[1]), 32'd0);
        @(negedge clock);
        check("ready_resp_l3", 32'(req_ready[1]), 32'd1);
        issue(1, 1'b0, 3'b010, 32'h38, 32'd0, 5'd3, 1'b0, 32'h0102_0304, 1'b1, t1);
        issue(1, 1'b0, 3'b010, 32'h38, 32'd0, 5'd4, 1'b0, 32'h0102_0304, 1'b1, t2);
        check("b2b_gap_l3", t2 - t1, 32'd3);
`ifdef LSU_SUBWORD_EN
        st(1, 3'b001, 32'h3C, 32'h0000_BEEF);
        ld(1, 3'b101, 32'h3C, 5'd5, 32'h0000_BEEF);
        ld(1, 3'b001, 32'h3C, 5'd6, 32'hFFFF_BEEF);
        ld(1, 3'b000, 32'h3D, 5'd7, 32'hFFFF_FFBE);
        bad(1, 1'b1, 3'b001, 32'h3E);
        bad(1, 1'b0, 3'b000, 32'h3E);
`endif
        drain();

        // Latency 4: reset while a load is waiting.
        st(2, 3'b010, 32'h10, 32'h1111_1111);
        ld(2, 3'b010, 32'h10, 5'd7, 32'h1111_1111);
        drain();
        issue(2, 1'b0, 3'b010, 32'h10, 32'd0, 5'd9, 1'b0, 32'd0, 1'b0, t1);
        reset[2]      = 1'b1;
        req_valid[2]  = 1'b1;
        req_write[2]  = 1'b1;
        req_funct3[2] = 3'b010;
        req_addr[2]   = 32'h10;
        req_wdata[2]  = 32'hBAD0_BAD0;
        @(negedge clock);
        chk_reset(2);
        reset[2]     = 1'b0;
        req_valid[2] = 1'b0;
        repeat (8) @(negedge clock);
        ld(2, 3'b010, 32'h10, 5'd3, 32'h1111_1111);
        drain();

        for (int i = 0; i < 3; i++) begin
            while (sbq[i].size() > 0) begin
                e = sbq[i].pop_front();
                checks++;
                failures++;
                $display("FAIL leftover_u%0d: event for edge %0d never seen",
                         i, e.cyc);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
